// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared encodings and FSM state type for control_unit
package control_pkg;

    // ALU operation encodings driven on alu_control
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_ORR = 4'h3;
    localparam logic [3:0] ALU_EOR = 4'h4;
    localparam logic [3:0] ALU_MOV = 4'h5;

    // Instruction classes
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    // Data-processing cmd field values
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Run-state FSM
    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10,
        ST_TRAP = 2'b11
    } cu_state_e;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - ARM condition-code evaluation against NZCV
module cond_check
    import control_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       cond_pass
);

    logic n, z, c, v;

    assign {n, z, c, v} = nzcv;

    // Standard ARM condition table; NV never passes
    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = ~z;
            COND_CS: cond_pass = c;
            COND_CC: cond_pass = ~c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = ~n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = ~v;
            COND_HI: cond_pass = c & ~z;
            COND_LS: cond_pass = ~c | z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = ~z & (n == v);
            COND_LE: cond_pass = z | (n != v);
            COND_AL: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - decode, condition gating, run-state FSM and retire counter; CU_SINGLE_STEP_EN enables HALT/step
module control_unit
    import control_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       cond,
    input  logic [1:0]       op,
    input  logic [5:0]       funct,
    input  logic [3:0]       rd,
    input  logic [4:0]       alu_flags,
    input  logic             halt_req,
    input  logic             step_req,
    output logic             pc_en,
    output logic             pc_src,
    output logic             mem_to_reg,
    output logic             mem_write,
    output logic             alu_src,
    output logic             reg_write,
    output logic [3:0]       alu_control,
    output logic [1:0]       reg_src,
    output logic             halted,
    output logic             trap,
    output logic [CNT_W-1:0] retire_count
);

    cu_state_e  state, state_next;
    logic [3:0] flags;
    logic       cond_pass;
    logic       illegal;
    logic       step_active;
    logic       exec;
    logic       dec_reg_write, dec_mem_write, dec_pc_src, dec_flag_upd;
    logic [3:0] cmd;
    logic       unused_bits;

    assign cmd = funct[4:1];

    cond_check u_cond_check (
        .cond      (cond),
        .nzcv      (flags),
        .cond_pass (cond_pass)
    );

    // An illegal op only matters when its condition passes; otherwise it is a no-op
    assign illegal = (op == OP_ILL) && cond_pass;

`ifdef CU_SINGLE_STEP_EN
    assign step_active = (state == ST_HALT) && step_req;
    assign unused_bits = alu_flags[4];
`else
    assign step_active = 1'b0;
    assign unused_bits = &{1'b0, alu_flags[4], halt_req, step_req};
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_BOOT;
        else      state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_BOOT: state_next = ST_RUN;
            ST_RUN: begin
                if (illegal) state_next = ST_TRAP;
`ifdef CU_SINGLE_STEP_EN
                else if (halt_req) state_next = ST_HALT;
`endif
            end
            ST_HALT: begin
`ifdef CU_SINGLE_STEP_EN
                // A step that lands on an illegal op traps like it would in RUN
                if (step_active && illegal) state_next = ST_TRAP;
                else if (!halt_req)         state_next = ST_RUN;
`else
                state_next = ST_RUN;
`endif
            end
            default: state_next = ST_TRAP;
        endcase
    end

    // FSM outputs: execute qualifier and status flags
    always_comb begin
        exec   = ((state == ST_RUN) || step_active) && !illegal;
        trap   = (state == ST_TRAP);
`ifdef CU_SINGLE_STEP_EN
        halted = (state == ST_HALT);
`else
        halted = 1'b0;
`endif
    end

    // Instruction decode, before condition/exec gating
    always_comb begin
        dec_reg_write = 1'b0;
        dec_mem_write = 1'b0;
        dec_pc_src    = 1'b0;
        dec_flag_upd  = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src       = 1'b0;
        alu_control   = ALU_ADD;
        reg_src       = 2'b00;
        case (op)
            OP_DP: begin
                alu_src = funct[5];
                case (cmd)
                    CMD_ADD: begin alu_control = ALU_ADD; dec_reg_write = 1'b1; end
                    CMD_SUB: begin alu_control = ALU_SUB; dec_reg_write = 1'b1; end
                    CMD_AND: begin alu_control = ALU_AND; dec_reg_write = 1'b1; end
                    CMD_ORR: begin alu_control = ALU_ORR; dec_reg_write = 1'b1; end
                    CMD_EOR: begin alu_control = ALU_EOR; dec_reg_write = 1'b1; end
                    CMD_MOV: begin alu_control = ALU_MOV; dec_reg_write = 1'b1; end
                    CMD_CMP: alu_control = ALU_SUB;
                    default: alu_control = ALU_ADD;
                endcase
                // Unsupported cmds fall through with no write and no flag update
                dec_flag_upd = (dec_reg_write && funct[0]) || (cmd == CMD_CMP);
                dec_pc_src   = dec_reg_write && (rd == 4'd15);
            end
            OP_MEM: begin
                alu_src = 1'b1;
                if (funct[0]) begin
                    mem_to_reg    = 1'b1;
                    dec_reg_write = 1'b1;
                    dec_pc_src    = (rd == 4'd15);
                end else begin
                    dec_mem_write = 1'b1;
                    reg_src[0]    = 1'b1;
                end
            end
            OP_BR: begin
                reg_src[1] = 1'b1;
                alu_src    = 1'b1;
                dec_pc_src = 1'b1;
            end
            default: ;
        endcase
    end

    // Architectural side effects only when the instruction really executes
    always_comb begin
        pc_en     = exec;
        reg_write = dec_reg_write && cond_pass && exec;
        mem_write = dec_mem_write && cond_pass && exec;
        pc_src    = dec_pc_src    && cond_pass && exec;
    end

    // NZCV register and retired-instruction counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags        <= 4'b0000;
            retire_count <= '0;
        end else begin
            if (exec && cond_pass && (op == OP_DP) && dec_flag_upd)
                flags <= alu_flags[3:0];
            if (exec)
                retire_count <= retire_count + CNT_W'(1);
        end
    end

endmodule
